alu_cmd_parser: RTL and testbench

Front-end packet parser between the UART receiver and the ALU arithmetic units. It consumes the received byte stream and decodes the 4-byte packet header (opcode, reserved, length LSB, length MSB). Payload bytes go either straight to the echo path or, packed little-endian into 32-bit operand words, to the arithmetic units. Malformed packets are drained and flagged so the stream resynchronises on the next header.

---
 rtl/alu_cmd_parser.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_cmd_parser.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_parser.sv
// Packet parser between the UART receiver and the ALU: decodes the 4-byte header and routes payload
// to the echo path or packs it into 32-bit operands. Define ALU_PARSER_TIMEOUT_EN for the idle-abort timer.
module alu_cmd_parser #(
  parameter int unsigned TimeoutCycles = 1_200_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  opcode_o,
  output logic [7:0]  echo_data_o,
  output logic        echo_valid_o,
  input  logic        echo_ready_i,
  output logic [31:0] operand_o,
  output logic        operand_valid_o,
  output logic        operand_last_o,
  input  logic        operand_ready_i,
  output logic        error_o
);

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_ECHO_PAY,
    ST_ARITH_PAY,
    ST_DRAIN
  } state_e;

  localparam logic [7:0] OpEcho = 8'hEC;
  localparam logic [7:0] OpAdd  = 8'hA0;
  localparam logic [7:0] OpMul  = 8'hA1;
  localparam logic [7:0] OpDiv  = 8'hA2;

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [23:0] acc_q, acc_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  echo_data_q, echo_data_d;
  logic        echo_valid_q, echo_valid_d;
  logic [31:0] operand_q, operand_d;
  logic        operand_valid_q, operand_valid_d;
  logic        operand_last_q, operand_last_d;
  logic        error_q, error_d;

  logic        accept;
  logic        last_byte;
  logic        is_arith;
  logic [15:0] rx_len;

`ifdef ALU_PARSER_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TimeoutCycles == 0);
`endif

  // An output register that is draining this cycle counts as free, which keeps full throughput.
  always_comb begin
    rx_ready_o = 1'b1;
    case (state_q)
      ST_ECHO_PAY:  rx_ready_o = !echo_valid_q || echo_ready_i;
      ST_ARITH_PAY: rx_ready_o = !operand_valid_q || operand_ready_i;
      default:      rx_ready_o = 1'b1;
    endcase
  end

  assign accept    = rx_valid_i && rx_ready_o;
  assign rx_len    = {rx_data_i, len_lo_q};
  assign last_byte = (pay_cnt_q == 16'd1);
  assign is_arith  = (opcode_q == OpAdd) || (opcode_q == OpMul) || (opcode_q == OpDiv);

  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    len_lo_d        = len_lo_q;
    pay_cnt_d       = pay_cnt_q;
    acc_d           = acc_q;
    byte_idx_d      = byte_idx_q;
    echo_data_d     = echo_data_q;
    echo_valid_d    = echo_valid_q;
    operand_d       = operand_q;
    operand_valid_d = operand_valid_q;
    operand_last_d  = operand_last_q;
    error_d         = 1'b0;
`ifdef ALU_PARSER_TIMEOUT_EN
    idle_cnt_d      = idle_cnt_q;
`endif

    if (echo_valid_q && echo_ready_i) begin
      echo_valid_d = 1'b0;
    end
    if (operand_valid_q && operand_ready_i) begin
      operand_valid_d = 1'b0;
      operand_last_d  = 1'b0;
    end

    case (state_q)
      ST_OPCODE: begin
        if (accept) begin
          opcode_d = rx_data_i;
          state_d  = ST_RSVD;
        end
      end
      ST_RSVD: begin
        if (accept) begin
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_lo_d = rx_data_i;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          state_d = ST_OPCODE;
          if (rx_len < 16'd4) begin
            error_d = 1'b1;
          end else if (rx_len == 16'd4) begin
            error_d = is_arith;
          end else begin
            pay_cnt_d  = rx_len - 16'd4;
            acc_d      = '0;
            byte_idx_d = '0;
            if (opcode_q == OpEcho) begin
              state_d = ST_ECHO_PAY;
            end else if (is_arith) begin
              state_d = ST_ARITH_PAY;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_ECHO_PAY: begin
        if (accept) begin
          pay_cnt_d    = pay_cnt_q - 16'd1;
          echo_data_d  = rx_data_i;
          echo_valid_d = 1'b1;
          if (last_byte) begin
            state_d = ST_OPCODE;
          end
        end
      end
      ST_ARITH_PAY: begin
        if (accept) begin
          pay_cnt_d  = pay_cnt_q - 16'd1;
          byte_idx_d = byte_idx_q + 2'd1;
          acc_d      = {rx_data_i, acc_q[23:8]};
          if (byte_idx_q == 2'd3) begin
            // Fewer than 4 bytes left means no further complete word, so this one is last.
            operand_d       = {rx_data_i, acc_q};
            operand_valid_d = 1'b1;
            operand_last_d  = (pay_cnt_q <= 16'd4);
            acc_d           = '0;
          end
          if (last_byte) begin
            error_d    = (byte_idx_q != 2'd3);
            acc_d      = '0;
            byte_idx_d = '0;
            state_d    = ST_OPCODE;
          end
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          pay_cnt_d = pay_cnt_q - 16'd1;
          if (last_byte) begin
            error_d = 1'b1;
            state_d = ST_OPCODE;
          end
        end
      end
      default: begin
        state_d = ST_OPCODE;
      end
    endcase

`ifdef ALU_PARSER_TIMEOUT_EN
    // Abort leaves already-valid output registers alone so they drain normally.
    if (accept) begin
      idle_cnt_d = '0;
    end else if (state_q != ST_OPCODE) begin
      if (idle_cnt_q >= 32'(TimeoutCycles)) begin
        error_d    = 1'b1;
        state_d    = ST_OPCODE;
        acc_d      = '0;
        byte_idx_d = '0;
        pay_cnt_d  = '0;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_OPCODE;
      opcode_q        <= '0;
      len_lo_q        <= '0;
      pay_cnt_q       <= '0;
      acc_q           <= '0;
      byte_idx_q      <= '0;
      echo_data_q     <= '0;
      echo_valid_q    <= 1'b0;
      operand_q       <= '0;
      operand_valid_q <= 1'b0;
      operand_last_q  <= 1'b0;
      error_q         <= 1'b0;
`ifdef ALU_PARSER_TIMEOUT_EN
      idle_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      opcode_q        <= opcode_d;
      len_lo_q        <= len_lo_d;
      pay_cnt_q       <= pay_cnt_d;
      acc_q           <= acc_d;
      byte_idx_q      <= byte_idx_d;
      echo_data_q     <= echo_data_d;
      echo_valid_q    <= echo_valid_d;
      operand_q       <= operand_d;
      operand_valid_q <= operand_valid_d;
      operand_last_q  <= operand_last_d;
      error_q         <= error_d;
`ifdef ALU_PARSER_TIMEOUT_EN
      idle_cnt_q      <= idle_cnt_d;
`endif
    end
  end

  assign opcode_o        = opcode_q;
  assign echo_data_o     = echo_data_q;
  assign echo_valid_o    = echo_valid_q;
  assign operand_o       = operand_q;
  assign operand_valid_o = operand_valid_q;
  assign operand_last_o  = operand_last_q;
  assign error_o         = error_q;

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Bench for alu_cmd_parser: directed and random packets scored against a packet-level reference model.
// The timeout scenario is included when ALU_PARSER_TIMEOUT_EN is defined.
module tb_alu_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic [7:0]  opcode;
  logic [7:0]  echoData;
  logic        echoValid;
  logic        echoReady = 1'b1;
  logic [31:0] operand;
  logic        operandValid;
  logic        operandLast;
  logic        operandReady = 1'b1;
  logic        error;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  byte unsigned pkt[$];
  byte unsigned expEcho[$];
  byte unsigned gotEcho[$];
  logic [32:0]  expOp[$];
  logic [32:0]  gotOp[$];
  int           expErr = 0;
  int           gotErr = 0;
  bit           holdOperand = 1'b0;
  int unsigned  readyPct = 75;

  always #5 clk = ~clk;

  alu_cmd_parser #(.TimeoutCycles(100)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rx_data_i       (rxData),
    .rx_valid_i      (rxValid),
    .rx_ready_o      (rxReady),
    .opcode_o        (opcode),
    .echo_data_o     (echoData),
    .echo_valid_o    (echoValid),
    .echo_ready_i    (echoReady),
    .operand_o       (operand),
    .operand_valid_o (operandValid),
    .operand_last_o  (operandLast),
    .operand_ready_i (operandReady),
    .error_o         (error)
  );

  // Random consumer backpressure, changed just after each clock edge.
  always @(posedge clk) begin
    #1;
    echoReady    = ($urandom_range(99) < readyPct);
    operandReady = holdOperand ? 1'b0 : ($urandom_range(99) < readyPct);
  end

  // Handshakes and error pulses are observed mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (!rst) begin
      if (echoValid && echoReady) gotEcho.push_back(echoData);
      if (operandValid && operandReady) gotOp.push_back({operandLast, operand});
      if (error) gotErr++;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    assert (got === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input byte unsigned b);
    int waitCycles = 0;
    bit taken = 1'b0;
    tick($urandom_range(2));
    rxData  = b;
    rxValid = 1'b1;
    while (!taken && waitCycles < 1000) begin
      @(negedge clk);
      taken = rxReady;
      @(posedge clk);
      #1;
      waitCycles++;
    end
    rxValid = 1'b0;
    if (!taken) checkOutput("rx_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic sendRange(input int lo, input int hi);
    for (int i = lo; i < hi; i++) applyStimulus(pkt[i]);
  endtask

  // Reference: expected outputs of one whole packet, straight from the packet rules.
  task automatic modelPacket();
    int len;
    int nPay;
    int nWords;
    int base;
    byte unsigned op;
    bit arith;
    logic [31:0] word;
    op    = pkt[0];
    arith = (op == 8'hA0) || (op == 8'hA1) || (op == 8'hA2);
    len   = int'(pkt[2]) + 256 * int'(pkt[3]);
    if (len < 4) begin
      expErr++;
    end else begin
      nPay = len - 4;
      if (op == 8'hEC) begin
        for (int i = 0; i < nPay; i++) expEcho.push_back(pkt[4 + i]);
      end else if (arith) begin
        nWords = nPay / 4;
        for (int w = 0; w < nWords; w++) begin
          base = 4 + 4 * w;
          word = {pkt[base + 3], pkt[base + 2], pkt[base + 1], pkt[base]};
          expOp.push_back({(w == nWords - 1), word});
        end
        if ((nPay % 4) != 0 || nWords == 0) expErr++;
      end else if (nPay > 0) begin
        expErr++;
      end
    end
  endtask

  task automatic sendPacket();
    modelPacket();
    sendRange(0, pkt.size());
  endtask

  task automatic settle();
    int n = 0;
    while ((gotEcho.size() != expEcho.size() || gotOp.size() != expOp.size()) && n < 2000) begin
      tick(1);
      n++;
    end
    tick(4);
  endtask

  task automatic compareScoreboard(input string tag);
    int n;
    checkOutput({tag, "_echo_count"}, 64'(gotEcho.size()), 64'(expEcho.size()));
    n = (gotEcho.size() < expEcho.size()) ? gotEcho.size() : expEcho.size();
    for (int i = 0; i < n; i++) checkOutput({tag, "_echo_byte"}, 64'(gotEcho[i]), 64'(expEcho[i]));
    checkOutput({tag, "_operand_count"}, 64'(gotOp.size()), 64'(expOp.size()));
    n = (gotOp.size() < expOp.size()) ? gotOp.size() : expOp.size();
    for (int i = 0; i < n; i++) checkOutput({tag, "_operand_word"}, 64'(gotOp[i]), 64'(expOp[i]));
    checkOutput({tag, "_error_pulses"}, 64'(gotErr), 64'(expErr));
    gotEcho.delete();
    expEcho.delete();
    gotOp.delete();
    expOp.delete();
    gotErr = 0;
    expErr = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rx_ready"}, 64'(rxReady), 64'd1);
    checkOutput({tag, "_opcode"}, 64'(opcode), 64'h00);
    checkOutput({tag, "_echo_valid"}, 64'(echoValid), 64'd0);
    checkOutput({tag, "_echo_data"}, 64'(echoData), 64'h00);
    checkOutput({tag, "_operand_valid"}, 64'(operandValid), 64'd0);
    checkOutput({tag, "_operand_last"}, 64'(operandLast), 64'd0);
    checkOutput({tag, "_operand"}, 64'(operand), 64'h0);
    checkOutput({tag, "_error"}, 64'(error), 64'd0);
  endtask

  initial begin
    int len;
    int choice;
    byte unsigned op;

    rst     = 1'b1;
    rxValid = 1'b0;
    rxData  = 8'h00;
    tick(3);
    checkResetState("reset");
    rst = 1'b0;
    tick(1);

    $display("[TB] echo packet");
    pkt = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    sendPacket();
    settle();
    compareScoreboard("echo");
    checkOutput("opcode_held", 64'(opcode), 64'hEC);

    $display("[TB] add packet");
    pkt = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hE7, 8'h00, 8'h00, 8'h00};
    sendPacket();
    settle();
    compareScoreboard("add");

    $display("[TB] malformed packets then recovery");
    pkt = {8'hA2, 8'h00, 8'h06, 8'h00, 8'h53, 8'h21};
    sendPacket();
    pkt = {8'h55, 8'h00, 8'h05, 8'h00, 8'hFF};
    sendPacket();
    pkt = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h21};
    sendPacket();
    settle();
    compareScoreboard("malformed");

    $display("[TB] operand backpressure");
    holdOperand = 1'b1;
    tick(1);
    pkt = {8'hA1, 8'h00, 8'h10, 8'h00,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    modelPacket();
    sendRange(0, 8);
    checkOutput("bp_operand_valid", 64'(operandValid), 64'd1);
    checkOutput("bp_operand_word", 64'(operand), 64'h44332211);
    checkOutput("bp_rx_ready_low", 64'(rxReady), 64'd0);
    tick(20);
    checkOutput("bp_rx_ready_held_low", 64'(rxReady), 64'd0);
    checkOutput("bp_operand_held", 64'({operandValid, operand}), {31'd0, 1'b1, 32'h44332211});
    holdOperand = 1'b0;
    sendRange(8, pkt.size());
    settle();
    compareScoreboard("backpressure");

    $display("[TB] reset mid-packet");
    pkt = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01};
    sendRange(0, pkt.size());
    rst = 1'b1;
    tick(1);
    checkResetState("mid_reset");
    tick(1);
    rst = 1'b0;
    tick(1);
    pkt = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h05, 8'h06, 8'h07, 8'h08};
    sendPacket();
    settle();
    compareScoreboard("after_reset");

    $display("[TB] length boundaries");
    pkt = {8'hEC, 8'h00, 8'h04, 8'h00};
    sendPacket();
    pkt = {8'hA1, 8'h00, 8'h04, 8'h00};
    sendPacket();
    pkt = {8'hA0, 8'h00, 8'h02, 8'h00};
    sendPacket();
    pkt = {8'hA0, 8'h00, 8'h09, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h77};
    sendPacket();
    settle();
    compareScoreboard("boundary");

    $display("[TB] random packets");
    for (int k = 0; k < 40; k++) begin
      choice = $urandom_range(4);
      case (choice)
        0: op = 8'hEC;
        1: op = 8'hA0;
        2: op = 8'hA1;
        3: op = 8'hA2;
        default: op = 8'($urandom_range(255));
      endcase
      len = $urandom_range(22);
      pkt = {op, 8'($urandom_range(255)), 8'(len), 8'h00};
      for (int i = 4; i < len; i++) pkt.push_back(8'($urandom_range(255)));
      sendPacket();
    end
    settle();
    compareScoreboard("random");

`ifdef ALU_PARSER_TIMEOUT_EN
    $display("[TB] idle timeout");
    pkt = {8'hEC, 8'h00, 8'h08, 8'h00};
    sendRange(0, pkt.size());
    expErr = 1;
    tick(105);
    pkt = {8'hEC, 8'h00, 8'h05, 8'h00, 8'h21};
    sendPacket();
    settle();
    compareScoreboard("timeout");
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
